// File: rtl/stack_cmd_driver.sv
// Request-side front end for a small LIFO stack: accepts push/pop/get requests,
// sequences them onto the stack pins and returns one response per operation.
module stack_cmd_driver #(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 3,
  parameter int DEPTH  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [IDX_W-1:0]  req_index,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [1:0]        stk_command,
  output logic [IDX_W-1:0]  stk_index,
  inout  wire  [DATA_W-1:0] stk_data,
  output logic [2:0]        count
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_GET  = 2'b11;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          count_q, count_d;
  logic [1:0]          stk_command_q, stk_command_d;
  logic [IDX_W-1:0]    stk_index_q, stk_index_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                push_drive;

  // The stack's pointers wrap silently, so anything it cannot honour is
  // rejected here using our own occupancy count.
  function automatic logic reject(input logic [1:0] op, input logic [IDX_W-1:0] idx,
                                  input logic [2:0] cnt);
    case (op)
      OP_PUSH: reject = (cnt == DEPTH_C);
      OP_POP:  reject = (cnt == 3'd0);
      OP_GET:  reject = (32'(idx) >= 32'(cnt));
      default: reject = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    count_d       = count_q;
    stk_command_d = stk_command_q;
    stk_index_d   = stk_index_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_op != OP_NOP) begin
          op_d   = req_op;
          data_d = req_data;
          if (reject(req_op, req_index, count_q)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d       = ISSUE;
            stk_command_d = req_op;
            stk_index_d   = (req_op == OP_GET) ? req_index : '0;
          end
        end
      end
      ISSUE: begin
        stk_command_d = OP_NOP;
        stk_index_d   = '0;
        if (op_q == OP_PUSH) begin
          count_d     = count_q + 3'd1;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end else begin
          if (op_q == OP_POP) count_d = count_q - 3'd1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Stack presents read data during this cycle; sample it on the closing edge.
        rsp_data_d  = stk_data;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_q          <= OP_NOP;
      data_q        <= '0;
      count_q       <= '0;
      stk_command_q <= OP_NOP;
      stk_index_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      count_q       <= count_d;
      stk_command_q <= stk_command_d;
      stk_index_q   <= stk_index_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // Bus is ours only while a push is being issued; reset forces IDLE, so high-Z then too.
  assign push_drive  = (state_q == ISSUE) && (op_q == OP_PUSH);
  assign stk_data    = push_drive ? data_q : {DATA_W{1'bz}};

  assign req_ready   = reset && (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign stk_command = stk_command_q;
  assign stk_index   = stk_index_q;
  assign count       = count_q;

endmodule

// File: tb/tb_stack_cmd_driver.sv
// Scoreboard bench for stack_cmd_driver with a behavioural 5-entry stack on the pins.
module tb_stack_cmd_driver;

  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, GET = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, rsp_ready;
  logic       req_ready, rsp_valid, rsp_err;
  logic [1:0] req_op, stk_command;
  logic [3:0] req_data, rsp_data;
  logic [2:0] req_index, stk_index, count;
  wire  [3:0] stk_data;

  logic [3:0] stk_drv;
  logic       stk_drv_en;
  logic [3:0] mem [0:7];
  int         sp;

  typedef struct { logic [3:0] data; logic err; int lat; } rsp_exp_t;
  typedef struct { logic [1:0] cmd; logic [3:0] data; logic [2:0] idx; } cmd_exp_t;
  rsp_exp_t exp_q[$];
  cmd_exp_t cmd_q[$];

  int checks = 0, passed = 0;
  int cyc = 0, accept_cyc = 0;
  bit seen_valid = 0;

  stack_cmd_driver #(.DATA_W(4), .IDX_W(3), .DEPTH(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_command(stk_command), .stk_index(stk_index), .stk_data(stk_data), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else passed++;
  endfunction

  // Behavioural stack: acts on the edge closing ISSUE, drives read data the next cycle.
  assign stk_data = stk_drv_en ? stk_drv : 4'bzzzz;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= 0;
      stk_drv_en <= 1'b0;
      stk_drv <= 4'd0;
    end else begin
      stk_drv_en <= 1'b0;
      case (stk_command)
        PUSH: begin mem[sp[2:0]] <= stk_data; sp <= sp + 1; end
        POP:  begin stk_drv <= mem[3'(sp - 1)]; stk_drv_en <= 1'b1; sp <= sp - 1; end
        GET:  begin stk_drv <= mem[3'(sp - 1 - int'(stk_index))]; stk_drv_en <= 1'b1; end
        default: ;
      endcase
    end
  end

  // Monitor: response scoreboard, latency and stack-command pulses.
  always @(negedge clk) begin
    rsp_exp_t e;
    cmd_exp_t c;
    if (!reset) begin
      seen_valid = 0;
    end else begin
      if (req_valid && req_ready && req_op != NOP) accept_cyc = cyc + 1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = exp_q[0];
          if (!seen_valid) begin
            chk("rsp_latency", cyc - accept_cyc + 1, e.lat);
            seen_valid = 1;
          end
          chk("rsp_data", int'(rsp_data), int'(e.data));
          chk("rsp_err", int'(rsp_err), int'(e.err));
          chk("req_ready_busy", int'(req_ready), 0);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            seen_valid = 0;
          end
        end
      end
      if (stk_command != NOP) begin
        if (cmd_q.size() == 0) chk("stk_cmd_unexpected", int'(stk_command), 0);
        else begin
          c = cmd_q.pop_front();
          chk("stk_command", int'(stk_command), int'(c.cmd));
          chk("stk_index", int'(stk_index), int'(c.idx));
          if (c.cmd == PUSH) chk("stk_data_push", int'(stk_data), int'(c.data));
        end
      end
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [3:0] d, input logic [2:0] idx,
                       input logic [3:0] exp_d, input logic exp_err);
    if (op != NOP) begin
      exp_q.push_back('{exp_d, exp_err, exp_err ? 1 : ((op == PUSH) ? 2 : 3)});
      if (!exp_err) cmd_q.push_back('{op, (op == PUSH) ? d : 4'd0, (op == GET) ? idx : 3'd0});
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_data = d; req_index = idx;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready) break;
      if (n == 59) chk("accept_timeout", 1, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = NOP;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready && !rsp_valid) break;
      if (n == 59) chk("idle_timeout", 1, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = NOP; req_data = 4'd0; req_index = 3'd0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_stk_command", int'(stk_command), 0);
    chk("rst_stk_index", int'(stk_index), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("release_req_ready", int'(req_ready), 1);

    do_op(PUSH, 4'd3, 3'd0, 4'd0, 1'b0);
    do_op(PUSH, 4'd7, 3'd0, 4'd0, 1'b0);
    do_op(PUSH, 4'd9, 3'd0, 4'd0, 1'b0);
    wait_idle();
    chk("count_after_3push", int'(count), 3);

    do_op(GET, 4'd0, 3'd0, 4'd9, 1'b0);
    do_op(GET, 4'd0, 3'd1, 4'd7, 1'b0);
    do_op(GET, 4'd0, 3'd2, 4'd3, 1'b0);
    do_op(GET, 4'd0, 3'd3, 4'd0, 1'b1);
    do_op(GET, 4'd0, 3'd7, 4'd0, 1'b1);
    do_op(NOP, 4'd5, 3'd0, 4'd0, 1'b0);
    wait_idle();
    chk("count_after_get", int'(count), 3);

    do_op(POP, 4'd0, 3'd0, 4'd9, 1'b0);
    do_op(POP, 4'd0, 3'd0, 4'd7, 1'b0);
    do_op(POP, 4'd0, 3'd0, 4'd3, 1'b0);
    wait_idle();
    chk("count_after_3pop", int'(count), 0);
    do_op(POP, 4'd0, 3'd0, 4'd0, 1'b1);
    wait_idle();
    chk("count_after_underflow", int'(count), 0);

    for (int i = 1; i <= 5; i++) do_op(PUSH, 4'(i), 3'd0, 4'd0, 1'b0);
    do_op(PUSH, 4'd6, 3'd0, 4'd0, 1'b1);
    wait_idle();
    chk("count_full", int'(count), 5);
    do_op(GET, 4'd0, 3'd0, 4'd5, 1'b0);
    do_op(GET, 4'd0, 3'd4, 4'd1, 1'b0);
    wait_idle();

    // Response stall: downstream holds off for 4 cycles.
    rsp_ready = 1'b0;
    do_op(POP, 4'd0, 3'd0, 4'd5, 1'b0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (n == 19) chk("stall_valid_timeout", 1, 0);
    end
    repeat (3) @(negedge clk);
    chk("stall_rsp_valid", int'(rsp_valid), 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_release_ready", int'(req_ready), 1);
    chk("stall_release_valid", int'(rsp_valid), 0);
    chk("count_after_stall_pop", int'(count), 4);

    // Reset asserted while a pop is in CAPTURE.
    cmd_q.push_back('{POP, 4'd0, 3'd0});
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = POP;
    @(negedge clk);
    chk("abort_accept_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = NOP;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_count", int'(count), 0);
    chk("abort_stk_command", int'(stk_command), 0);
    chk("abort_req_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", int'(req_ready), 1);
    do_op(POP, 4'd0, 3'd0, 4'd0, 1'b1);
    wait_idle();
    chk("count_final", int'(count), 0);
    repeat (2) @(negedge clk);
    chk("rsp_queue_drained", exp_q.size(), 0);
    chk("cmd_queue_drained", cmd_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/stack_cmd_driver.md
# stack_cmd_driver

Request-side front end for the 5-entry 4-bit LIFO stack. It accepts push/pop/get operations from an upstream producer over a valid/ready handshake and sequences them onto the stack's `command`/`index` pins and shared tri-state `io_data` bus. It captures the stack's read data and returns a single response per operation over a second valid/ready handshake. It keeps its own occupancy count so that overflow, underflow and out-of-range gets are rejected before they reach the stack, whose pointers silently wrap.

## Interface
- `DATA_W`, 4: data width, equals stack word width
- `IDX_W`, 3: get-index width
- `DEPTH`, 5: stack capacity in entries
- `clk`  in  1  single clock, all state on posedge
- `reset`  in  1  asynchronous, active-low; low clears all state immediately
- `req_valid`  in  1  upstream request present
- `req_ready`  out  1  driver can accept; high only in IDLE
- `req_op`  in  2  00 nop, 01 push, 10 pop, 11 get
- `req_data`  in  DATA_W  push payload
- `req_index`  in  IDX_W  get depth (0 = top)
- `rsp_valid`  out  1  response present; held until taken
- `rsp_ready`  in  1  downstream accepts response
- `rsp_data`  out  DATA_W  pop/get value; 0 for push and for errors
- `rsp_err`  out  1  operation rejected (overflow/underflow/range)
- `stk_command`  out  2  to stack `command`
- `stk_index`  out  IDX_W  to stack `index`
- `stk_data`  inout  DATA_W  to stack `io_data`
- `count`  out  3  current occupancy, 0..DEPTH

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, latch op/data/index.
  - nop: consumed, no response, stay IDLE.
  - Push with `count`==DEPTH, pop with `count`==0, or get with `req_index` >= `count`: no stack command is issued. Go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `stk_command`=latched op, `stk_index`=latched index (0 for push/pop).
  - `stk_data` driven with latched data only for push; high-Z for pop/get.
  - `count` is +1 for push or -1 for pop at the end of the cycle; unchanged for get.
  - Push goes to RESP; pop/get go to CAPTURE.
- CAPTURE (1 cycle): `stk_command`=00, `stk_data` high-Z. Sample `stk_data` into `rsp_data` at the end of the cycle, then go to RESP.
- RESP: `rsp_valid`=1 with stable `rsp_data`/`rsp_err`. On `rsp_ready` go to IDLE and drop `rsp_valid`.
- `stk_data` is driven by this block only in ISSUE with op=push; it is high-Z in every other state and during reset.
- `stk_command`, `stk_index`, `rsp_*` and `count` are registered outputs. `req_ready` is decoded from state.
- Arithmetic: `count` is 3-bit and saturation is unreachable because of the error checks. The index compare is unsigned at IDX_W bits, so indices 5..7 always error.

## Timing
- Reset (`reset` low, asynchronous):
  - State IDLE, `count`=0, `stk_command`=00, `stk_index`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `stk_data` high-Z.
  - `req_ready` rises on release.
- Reset mid-operation aborts: the latched request and any pending response are discarded. The stack is reset from the same net, so `count`=0 stays consistent with it.
- Valid path latency, counted from the accept edge to the first cycle `rsp_valid`=1:
  - push: 2 cycles
  - pop/get: 3 cycles
- Error path latency: 1 cycle.
- Throughput: one op per 3 cycles for push, 4 for pop/get, 2 for errors, plus any `rsp_ready` stall. A nop takes 1 cycle.
- `stk_command` is non-zero for exactly one cycle per issued op; the stack acts on the closing edge of ISSUE.
- `req_valid` arriving while not in IDLE is not accepted; upstream holds it.
- `rsp_valid` and `rsp_ready` high in the same cycle completes the handshake; the next request can be accepted in the following cycle.

## Test plan
- Reset then push 3,7,9 -> three responses with `rsp_err`=0, `rsp_data`=0; `count`=3; `stk_command`=01 for one cycle each with `stk_data`=3,7,9.
- From that state, get index 0,1,2 -> `rsp_data`=9,7,3, each 3 cycles after accept; `count` stays 3. Get index 3 -> `rsp_err`=1, no `stk_command` pulse.
- Pop ×3 -> `rsp_data`=9,7,3, then `count`=0. A 4th pop -> `rsp_err`=1, `rsp_data`=0, `stk_command` stays 00.
- Push 1..5 then push 6 -> the 6th returns `rsp_err`=1; `count`=5; a subsequent get index 0 returns 5.
- Hold `rsp_ready`=0 for 4 cycles after a pop -> `rsp_valid`/`rsp_data` stable, `req_ready`=0 throughout; release -> IDLE the next cycle.
- Assert `reset` low during CAPTURE of a pop -> immediately `rsp_valid`=0, `count`=0, `stk_data` high-Z. After release, a pop returns `rsp_err`=1.
